rv_lsu: RTL

RV_LSU -- requirements
Module: rv_lsu

---
 rtl/RV32i_pkg.sv | 30 +++
 rtl/rv_lsu_align.sv | 58 +++++
 rtl/rv_lsu.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/RV32i_pkg.sv
// Shared load/store definitions: access size encodings, response error codes,
// LSU state type and the natural-alignment check.
package RV32i_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_D = 2'b11;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b10;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT,
        LSU_DONE
    } lsu_state_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] lo);
        case (size)
            SIZE_H:  return lo[0];
            SIZE_W:  return |lo[1:0];
            SIZE_D:  return |lo;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv_lsu_align.sv
// Combinational lane logic: byte-enable mask, write-data lane shift and
// read-data right-align with zero/sign extension.
module rv_lsu_align
    import RV32i_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    localparam int unsigned NB    = XLEN / 8,
    localparam int unsigned OFF_W = $clog2(NB)
) (
    input  logic [1:0]       i_size,
    input  logic [OFF_W-1:0] i_off,
    input  logic             i_unsigned,
    input  logic [XLEN-1:0]  i_wdata,
    input  logic [XLEN-1:0]  i_rdo,
    output logic [NB-1:0]    o_ble,
    output logic [XLEN-1:0]  o_di,
    output logic [XLEN-1:0]  o_rdata
);

    localparam int unsigned IDX_W = $clog2(XLEN);

    logic [NB-1:0]    w_mask;
    logic [XLEN-1:0]  w_wr_shift;
    logic [XLEN-1:0]  w_rd_shift;
    int unsigned      w_rd_bits;
    logic [IDX_W-1:0] w_sign_idx;
    logic             w_rd_sign;

    always_comb begin
        w_mask = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            w_mask[i] = (i < (32'd1 << i_size));
        end
        o_ble      = w_mask << i_off;
        w_wr_shift = i_wdata << {i_off, 3'b000};
        o_di       = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            o_di[i*8 +: 8] = o_ble[i] ? w_wr_shift[i*8 +: 8] : 8'h00;
        end
    end

    // Access width is clamped to XLEN so the sign-bit index stays in range
    // even for a size code the datapath cannot carry.
    always_comb begin
        w_rd_shift = i_rdo >> {i_off, 3'b000};
        w_rd_bits  = 32'd8 << i_size;
        if (w_rd_bits > XLEN) begin
            w_rd_bits = XLEN;
        end
        w_sign_idx = IDX_W'(w_rd_bits - 32'd1);
        w_rd_sign  = ~i_unsigned & w_rd_shift[w_sign_idx];
        o_rdata    = '0;
        for (int unsigned i = 0; i < XLEN; i++) begin
            o_rdata[i] = (i < w_rd_bits) ? w_rd_shift[i] : w_rd_sign;
        end
    end

endmodule

// File: rtl/rv_lsu.sv
// Load/store unit: accepts one core access at a time, runs a single
// request/grant (+ read-data) memory transaction, returns a one-cycle response.
module rv_lsu
    import RV32i_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                clk_i,
    input  logic                resetn_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_we_i,
    input  logic [1:0]          req_size_i,
    input  logic                req_unsigned_i,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [XLEN-1:0]     req_wdata_i,
    output logic                rsp_valid_o,
    output logic [XLEN-1:0]     rsp_rdata_o,
    output logic [1:0]          rsp_err_o,
    output logic                dmem_req_o,
    input  logic                dmem_gnt_i,
    output logic                dmem_we_o,
    output logic [ADDR_W-1:0]   dmem_add_o,
    output logic [XLEN/8-1:0]   dmem_ble_o,
    output logic [XLEN-1:0]     dmem_di_o,
    input  logic                dmem_rvalid_i,
    input  logic [XLEN-1:0]     dmem_do_i
);

    localparam int unsigned NB    = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(NB);

    lsu_state_t        r_state;
    lsu_state_t        w_state_nxt;
    logic              r_we;
    logic              r_unsigned;
    logic [1:0]        r_size;
    logic [1:0]        r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [XLEN-1:0]   r_rdata;

    logic [1:0]        w_err;
    logic              w_accept;
    logic [NB-1:0]     w_ble;
    logic [XLEN-1:0]   w_di;
    logic [XLEN-1:0]   w_rdata;
    logic [ADDR_W-1:0] w_lane_add;

    // Illegal size outranks misalignment.
    always_comb begin
        w_err = ERR_OK;
        if ((XLEN == 32) && (req_size_i == SIZE_D)) begin
            w_err = ERR_ILLEGAL;
        end else if (is_misaligned(req_size_i, req_addr_i[2:0])) begin
            w_err = ERR_MISALIGN;
        end
    end

    assign w_accept   = (r_state == LSU_IDLE) && req_valid_i;
    assign w_lane_add = r_addr & ~ADDR_W'(NB - 1);

    rv_lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .i_size     (r_size),
        .i_off      (r_addr[OFF_W-1:0]),
        .i_unsigned (r_unsigned),
        .i_wdata    (r_wdata),
        .i_rdo      (dmem_do_i),
        .o_ble      (w_ble),
        .o_di       (w_di),
        .o_rdata    (w_rdata)
    );

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state <= LSU_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_we       <= 1'b0;
            r_unsigned <= 1'b0;
            r_size     <= '0;
            r_err      <= ERR_OK;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
        end else if (w_accept) begin
            r_err   <= w_err;
            r_rdata <= '0;
            if (w_err == ERR_OK) begin
                r_we       <= req_we_i;
                r_unsigned <= req_unsigned_i;
                r_size     <= req_size_i;
                r_addr     <= req_addr_i;
                r_wdata    <= req_wdata_i;
            end
        end else if ((r_state == LSU_WAIT) && dmem_rvalid_i) begin
            r_rdata <= w_rdata;
        end
    end

    // Memory-side fields come straight from the latched access, so they stay
    // constant for the whole REQ phase regardless of core-side activity.
    always_comb begin
        w_state_nxt = r_state;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        rsp_rdata_o = '0;
        rsp_err_o   = ERR_OK;
        dmem_req_o  = 1'b0;
        dmem_we_o   = 1'b0;
        dmem_add_o  = '0;
        dmem_ble_o  = '0;
        dmem_di_o   = '0;
        case (r_state)
            LSU_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    w_state_nxt = (w_err == ERR_OK) ? LSU_REQ : LSU_DONE;
                end
            end
            LSU_REQ: begin
                dmem_req_o = 1'b1;
                dmem_we_o  = r_we;
                dmem_add_o = w_lane_add;
                dmem_ble_o = w_ble;
                dmem_di_o  = r_we ? w_di : '0;
                if (dmem_gnt_i) begin
                    w_state_nxt = r_we ? LSU_DONE : LSU_WAIT;
                end
            end
            LSU_WAIT: begin
                if (dmem_rvalid_i) begin
                    w_state_nxt = LSU_DONE;
                end
            end
            LSU_DONE: begin
                rsp_valid_o = 1'b1;
                rsp_rdata_o = r_rdata;
                rsp_err_o   = r_err;
                w_state_nxt = LSU_IDLE;
            end
            default: begin
                w_state_nxt = LSU_IDLE;
            end
        endcase
    end

endmodule
